// File: rtl/mmio_peripherals_pkg.sv
// rtl/mmio_peripherals_pkg.sv - shared rv32i and peripheral register definitions
package mmio_peripherals_pkg;

  // rv32i base opcodes used by the core's memory stage
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Peripheral register byte offsets inside the 256-byte window
  localparam logic [7:0] REG_LEDS     = 8'h00;
  localparam logic [7:0] REG_MTIME    = 8'h04;
  localparam logic [7:0] REG_MTIMECMP = 8'h08;
  localparam logic [7:0] REG_STATUS   = 8'h0C;
  localparam logic [7:0] REG_TXDATA   = 8'h10;

  // STATUS register bit positions
  localparam int STAT_IRQ     = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - circular TX byte FIFO with drop-on-full reporting
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_peripherals.sv
// rtl/mmio_peripherals.sv - LED, machine timer and TX FIFO memory-mapped peripherals
module mmio_peripherals
  import mmio_peripherals_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_ena,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic [7:0]  leds,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic          wr_sel;
  logic [7:0]    off;
  logic [31:0]   mtime;
  logic [31:0]   mtimecmp;
  logic [31:0]   status;
  logic [31:0]   rd_next;
  logic          tx_overflow;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          push_drop;
  logic          clr_irq;
  logic          clr_ovf;
  logic          unused_addr_lsbs;

  // Byte lanes are not supported; the two low address bits never select anything.
  assign unused_addr_lsbs = ^addr[1:0];

  assign sel      = (addr[31:8] == BASE_ADDR[31:8]);
  assign off      = {addr[7:2], 2'b00};
  assign wr_sel   = wr_ena && sel;
  assign push     = wr_sel && (off == REG_TXDATA);
  assign tx_valid = !fifo_empty;
  assign pop      = tx_valid && tx_ready;
  assign clr_irq  = wr_sel && (off == REG_STATUS) && wr_data[STAT_IRQ];
  assign clr_ovf  = wr_sel && (off == REG_STATUS) && wr_data[STAT_OVF];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_data[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (push_drop)
  );

  // Assemble STATUS and select read data from the pre-write register values
  always_comb begin
    status = '0;
    status[STAT_IRQ]   = timer_irq;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = tx_overflow;
    status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    rd_next = '0;
    if (sel) begin
      case (off)
        REG_LEDS:     rd_next = {24'd0, leds};
        REG_MTIME:    rd_next = mtime;
        REG_MTIMECMP: rd_next = mtimecmp;
        REG_STATUS:   rd_next = status;
        default:      rd_next = '0;
      endcase
    end
  end

  // Read response and window-hit flag, one cycle behind the request
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      hit     <= 1'b0;
    end else begin
      rd_data <= rd_next;
      hit     <= sel;
    end
  end

  // LED, timer and compare registers; a write to MTIME replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (rst) begin
      leds     <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (wr_sel && (off == REG_LEDS))     leds     <= wr_data[7:0];
      if (wr_sel && (off == REG_MTIMECMP)) mtimecmp <= wr_data;
      mtime <= (wr_sel && (off == REG_MTIME)) ? wr_data : mtime + 32'd1;
    end
  end

  // Sticky flags: a same-cycle set wins over a write-one-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_irq   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (mtime == mtimecmp) timer_irq <= 1'b1;
      else if (clr_irq)      timer_irq <= 1'b0;
      if (push_drop)         tx_overflow <= 1'b1;
      else if (clr_ovf)      tx_overflow <= 1'b0;
    end
  end

endmodule

// File: doc/mmio_peripherals.md
MMIO_PERIPHERALS -- requirements
Module: mmio_peripherals

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hF000_0000, peripheral window base; the window is 256 bytes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries; a power of two from 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port addr, input, 32 bits, byte address from the core memory interface.
REQ-006 SHALL have port wr_data, input, 32 bits, store data.
REQ-007 SHALL have port wr_ena, input, 1 bit, store strobe.
REQ-008 SHALL have port rd_data, output, 32 bits, registered read data.
REQ-009 SHALL have port hit, output, 1 bit, registered flag: the previous-cycle addr was in the window (drives the upstream read-data mux).
REQ-010 SHALL have port leds, output, 8 bits, LED register.
REQ-011 SHALL have port timer_irq, output, 1 bit, sticky timer-match flag.
REQ-012 SHALL have ports tx_valid (output, 1), tx_data (output, 8) and tx_ready (input, 1), forming the byte-stream handshake.

Function
REQ-013 SHALL define selection as sel = (addr[31:8] == BASE_ADDR[31:8]); the register offset is addr[7:0] and bits [1:0] are ignored.
REQ-014 SHALL implement this register map:
- 0x00 LEDS: RW, bits [7:0].
- 0x04 MTIME: RW.
- 0x08 MTIMECMP: RW.
- 0x0C STATUS: see REQ-019.
- 0x10 TXDATA: write-only; reads return 0.
REQ-015 SHALL act on a write only when wr_ena && sel; writes to unmapped offsets SHALL be ignored.
REQ-016 SHALL return read data one cycle after the request: rd_data equals the register value before any write in the request cycle; rd_data = 0 when the request was unselected or to an unmapped offset.
REQ-017 SHALL increment MTIME by 1 every cycle, wrapping 32'hFFFF_FFFF to 0; a write to MTIME loads wr_data in place of that cycle's increment.
REQ-018 SHALL set timer_irq on the edge after a cycle where MTIME == MTIMECMP; the flag is sticky.
REQ-019 SHALL define STATUS as:
- bit0 timer_irq.
- bit1 fifo_full.
- bit2 fifo_empty.
- bit3 tx_overflow (sticky).
- bits[8:4] fifo count.
- all other bits 0.
REQ-020 SHALL clear STATUS bit0 and bit3 when a 1 is written to the corresponding bit; other STATUS bits ignore writes.
REQ-021 SHALL give set priority over clear for timer_irq and tx_overflow when both occur in the same cycle.
REQ-022 SHALL push wr_data[7:0] into the FIFO on a TXDATA write.
REQ-023 SHALL drive tx_valid = !fifo_empty and tx_data = head entry, both straight from registers with no combinational path from addr or wr_data.
REQ-024 SHALL pop the head entry on a cycle with tx_valid && tx_ready.
REQ-025 SHALL handle a push when full as follows:
- accepted if a pop occurs in the same cycle; count unchanged.
- otherwise the byte is dropped and tx_overflow is set.
REQ-026 SHALL, on a simultaneous push and pop when not full, leave the count unchanged and keep FIFO order.
REQ-027 SHALL use circular read/write pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 SHALL, while rst is high, set: leds=0, MTIME=0, MTIMECMP=32'hFFFF_FFFF, timer_irq=0, tx_overflow=0, FIFO empty (pointers and count 0), rd_data=0, hit=0.
REQ-029 SHALL let rst override any same-cycle write, push or pop; an asserted reset mid-transfer discards all queued bytes.

Structure
REQ-030 SHALL place the register offset constants (LEDS, MTIME, MTIMECMP, STATUS, TXDATA) and the STATUS bit positions in the shared defines package beside the existing rv32i definitions.
REQ-031 SHALL implement the FIFO as one sub-module, tx_fifo, parameterised by depth and width.

Verification
REQ-032 SHALL cover LED write/read: store 32'h0000_00A5 to 0xF000_0000, then read -> leds=8'hA5; next-cycle rd_data=32'hA5 and hit=1.
REQ-033 SHALL cover the timer match: write MTIMECMP=20, then MTIME=10 -> timer_irq rises 11 cycles after the MTIME write; write STATUS=1 -> it clears; no reassertion until the next match.
REQ-034 SHALL cover FIFO fill with tx_ready=0: push 5 bytes 0x11..0x15 -> STATUS count=4, full=1, overflow=1; raise tx_ready -> 0x11..0x14 emitted in order, one per cycle, then tx_valid=0.
REQ-035 SHALL cover push when full with a simultaneous pop -> byte accepted, count stays 4, overflow unchanged.
REQ-036 SHALL cover an unselected address: read 0x0000_0010 -> rd_data=0, hit=0; write there -> no state change.
REQ-037 SHALL cover reset mid-operation: assert rst with 3 bytes queued and irq set -> all REQ-028 values hold on the next cycle; MTIME restarts from 0.
